instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: PC_W, default 16, instruction-word address width.
REQ-002 Parameter: OP_LIMM32_CODE, default 8'h02, opcode whose instruction occupies two words.
REQ-003 Parameter: OP_END_CODE, default 8'hFF, opcode that halts the sequencer.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset_n  in  1  reset; asynchronous, active-low.
REQ-006 Port: start  in  1  one-cycle pulse that begins execution from start_pc while IDLE or HALT.
REQ-007 Port: start_pc  in  PC_W  first instruction address.
REQ-008 Port: imem_req  out  1  instruction-memory read request.
REQ-009 Port: imem_addr  out  PC_W  read address, valid while imem_req=1.
REQ-010 Port: imem_ack  in  1  read data valid this cycle; ignored unless imem_req=1.
REQ-011 Port: imem_data  in  32  read data.
REQ-012 Port: instr0  out  32  first word of the current instruction.
REQ-013 Port: instr1  out  32  second word (LIMM32 only), else 0.
REQ-014 Port: current_state  out  4  state code to the datapath.
REQ-015 Port: jmp_valid  in  1  datapath-computed branch, sampled only in EXEC.
REQ-016 Port: jmp_addr  in  PC_W  branch target.
REQ-017 Port: stall  in  1  holds EXEC for another cycle.
REQ-018 Port: pc  out  PC_W  address of the current instruction's first word.
REQ-019 Port: halted  out  1  high while in HALT.

Function
REQ-020 State codes SHALL be IDLE=0, FETCH0=1, FETCH1=2, EXEC=3, HALT=15; current_state SHALL equal the registered state.
REQ-021 IDLE: imem_req=0; start -> FETCH0 with pc<=start_pc and fetch pointer fp<=start_pc.
REQ-022 FETCH0: imem_req=1, imem_addr=fp; on imem_ack, instr0<=imem_data, instr1<=0, fp<=fp+1.
REQ-023 FETCH0 transitions on ack: imem_data[31:24]==OP_LIMM32_CODE -> FETCH1; else -> EXEC. Without ack: stay, request held, address stable.
REQ-024 FETCH1: imem_req=1, imem_addr=fp; on imem_ack, instr1<=imem_data, fp<=fp+1, -> EXEC.
REQ-025 EXEC SHALL last exactly one cycle when stall=0; instr0/instr1 SHALL stay constant throughout EXEC.
REQ-026 EXEC with stall=1: remain in EXEC; jmp_valid ignored in that cycle.
REQ-027 EXEC, stall=0, instr0[31:24]==OP_END_CODE -> HALT, pc and fp unchanged.
REQ-028 EXEC, stall=0, jmp_valid=1 -> FETCH0 with pc<=jmp_addr and fp<=jmp_addr.
REQ-029 EXEC, stall=0, otherwise -> FETCH0 with pc<=fp.
REQ-030 OP_END_CODE SHALL take priority over jmp_valid in the same EXEC cycle.
REQ-031 Address arithmetic SHALL be modulo 2^PC_W; fp=2^PC_W-1 wraps to 0 without error.
REQ-032 HALT: imem_req=0, halted=1; start -> FETCH0 as from IDLE; other inputs ignored.
REQ-033 start SHALL be ignored in FETCH0, FETCH1 and EXEC.
REQ-034 imem_req SHALL be high only in FETCH0/FETCH1; one ack completes exactly one word.
REQ-035 Throughput: one-word instruction with zero-wait memory = 2 cycles (FETCH0, EXEC); LIMM32 = 3 cycles.

Reset
REQ-036 reset_n=0 SHALL immediately force state=IDLE, pc=0, fp=0, instr0=0, instr1=0, imem_req=0, halted=0, regardless of clk.
REQ-037 Reset asserted mid-fetch SHALL drop imem_req in that cycle; a later imem_ack SHALL be ignored.
REQ-038 After reset_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-039 start, start_pc=0x0010, zero-wait memory, word 0x01000005 -> FETCH0@0x0010, EXEC with instr0=0x01000005, instr1=0, next FETCH0@0x0011.
REQ-040 Word 0x02040000 then 0xDEADBEEF -> FETCH0, FETCH1, EXEC with instr1=0xDEADBEEF; next fetch address = start+2.
REQ-041 ack delayed 3 cycles in FETCH0 -> imem_req and imem_addr held stable 4 cycles, then EXEC.
REQ-042 EXEC with stall=1 for 2 cycles, then jmp_valid=1, jmp_addr=0x0100 -> 3 EXEC cycles, then FETCH0@0x0100, pc=0x0100.
REQ-043 OP_END_CODE word with jmp_valid=1 -> HALT, halted=1, imem_req=0; start with start_pc=0 -> FETCH0@0x0000.
REQ-044 PC_W=16, start_pc=0xFFFF, LIMM32 -> second fetch address 0x0000; reset_n pulsed during FETCH1 -> IDLE asynchronously, all outputs 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer.
// Fetches one or two instruction words per instruction, holds them stable
// through EXEC, then follows either the sequential pointer or a datapath
// branch. An END opcode parks the block in HALT until the next start pulse.
//
//   state  | code | meaning
//   IDLE   |  0   | after reset, waiting for start
//   FETCH0 |  1   | reading first instruction word at fp
//   FETCH1 |  2   | reading second word of a LIMM32 instruction at fp
//   EXEC   |  3   | instruction words presented to the datapath
//   HALT   |  15  | END opcode executed, waiting for start
module instr_sequencer #(
    parameter int unsigned PC_W           = 16,
    parameter logic [7:0]  OP_LIMM32_CODE = 8'h02,
    parameter logic [7:0]  OP_END_CODE    = 8'hFF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instr0,
    output logic [31:0]     instr1,
    output logic [3:0]      current_state,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_addr,
    input  logic            stall,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH0 = 4'd1;
    localparam logic [3:0] ST_FETCH1 = 4'd2;
    localparam logic [3:0] ST_EXEC   = 4'd3;
    localparam logic [3:0] ST_HALT   = 4'd15;

    logic [3:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fp_q, fp_d;
    logic [31:0]     instr0_q, instr0_d;
    logic [31:0]     instr1_q, instr1_d;

    // Fetch-pointer increment, naturally modulo 2^PC_W.
    logic [PC_W-1:0] fp_inc;
    assign fp_inc = fp_q + {{(PC_W-1){1'b0}}, 1'b1};

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            fp_q     <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fp_q     <= fp_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
        end
    end

    // Next-state and register updates. END wins over a branch, and a stalled
    // EXEC ignores jmp_valid entirely.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fp_d     = fp_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH0;
                    pc_d    = start_pc;
                    fp_d    = start_pc;
                end
            end
            ST_FETCH0: begin
                if (imem_ack) begin
                    instr0_d = imem_data;
                    instr1_d = '0;
                    fp_d     = fp_inc;
                    state_d  = (imem_data[31:24] == OP_LIMM32_CODE) ? ST_FETCH1 : ST_EXEC;
                end
            end
            ST_FETCH1: begin
                if (imem_ack) begin
                    instr1_d = imem_data;
                    fp_d     = fp_inc;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (instr0_q[31:24] == OP_END_CODE) begin
                        state_d = ST_HALT;
                    end else if (jmp_valid) begin
                        state_d = ST_FETCH0;
                        pc_d    = jmp_addr;
                        fp_d    = jmp_addr;
                    end else begin
                        state_d = ST_FETCH0;
                        pc_d    = fp_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        imem_req      = (state_q == ST_FETCH0) || (state_q == ST_FETCH1);
        imem_addr     = fp_q;
        halted        = (state_q == ST_HALT);
        current_state = state_q;
        pc            = pc_q;
        instr0        = instr0_q;
        instr1        = instr1_q;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: memory handshake driven by hand,
// expected values written out per step.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] start_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [3:0]  current_state;
    logic        jmp_valid;
    logic [15:0] jmp_addr;
    logic        stall;
    logic [15:0] pc;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_EX = 4'd3, S_HALT = 4'd15;

    instr_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_pc      (start_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr0        (instr0),
        .instr1        (instr1),
        .current_state (current_state),
        .jmp_valid     (jmp_valid),
        .jmp_addr      (jmp_addr),
        .stall         (stall),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [3:0] st, input logic [15:0] addr);
        check({tag, "_state"}, 32'(current_state), 32'(st));
        check({tag, "_req"},   32'(imem_req), 32'd1);
        check({tag, "_addr"},  32'(imem_addr), 32'(addr));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        start_pc  = 16'h0000;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        jmp_valid = 1'b0;
        jmp_addr  = 16'h0;
        stall     = 1'b0;

        // Reset state
        #2;
        check("rst_state",  32'(current_state), 32'(S_IDLE));
        check("rst_req",    32'(imem_req), 32'd0);
        check("rst_pc",     32'(pc), 32'd0);
        check("rst_instr0", instr0, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        reset_n = 1'b1;
        imem_ack = 1'b1;
        tick();
        tick();
        check("idle_hold", 32'(current_state), 32'(S_IDLE));
        check("idle_req",  32'(imem_req), 32'd0);
        imem_ack = 1'b0;

        // One-word instruction at 0x0010
        start = 1'b1; start_pc = 16'h0010;
        tick();
        start = 1'b0;
        check_fetch("t1_f0", S_F0, 16'h0010);
        check("t1_pc", 32'(pc), 32'h0010);
        imem_ack = 1'b1; imem_data = 32'h01000005;
        tick();
        imem_ack = 1'b0;
        check("t1_ex_state", 32'(current_state), 32'(S_EX));
        check("t1_ex_req",   32'(imem_req), 32'd0);
        check("t1_instr0",   instr0, 32'h01000005);
        check("t1_instr1",   instr1, 32'h0);
        tick();
        check_fetch("t1_next", S_F0, 16'h0011);
        check("t1_next_pc", 32'(pc), 32'h0011);

        // LIMM32 at 0x0011
        imem_ack = 1'b1; imem_data = 32'h02040000;
        tick();
        check_fetch("t2_f1", S_F1, 16'h0012);
        check("t2_f1_pc", 32'(pc), 32'h0011);
        imem_data = 32'hDEADBEEF;
        tick();
        imem_ack = 1'b0;
        check("t2_ex_state", 32'(current_state), 32'(S_EX));
        check("t2_instr0",   instr0, 32'h02040000);
        check("t2_instr1",   instr1, 32'hDEADBEEF);
        tick();
        check_fetch("t2_next", S_F0, 16'h0013);
        check("t2_next_pc", 32'(pc), 32'h0013);

        // Ack delayed 3 cycles; start ignored while fetching
        start = 1'b1; start_pc = 16'h0777;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch("t3_wait", S_F0, 16'h0013);
        end
        start = 1'b0;
        imem_ack = 1'b1; imem_data = 32'h01000000;
        check_fetch("t3_ackcyc", S_F0, 16'h0013);
        tick();
        imem_ack = 1'b0;
        check("t3_ex", 32'(current_state), 32'(S_EX));

        // Stall two cycles (branch and start ignored), then branch to 0x0100
        stall = 1'b1; jmp_valid = 1'b1; jmp_addr = 16'h0555; start = 1'b1;
        tick();
        check("t4_stall1", 32'(current_state), 32'(S_EX));
        check("t4_stall1_i0", instr0, 32'h01000000);
        tick();
        check("t4_stall2", 32'(current_state), 32'(S_EX));
        stall = 1'b0; start = 1'b0; jmp_addr = 16'h0100;
        tick();
        jmp_valid = 1'b0;
        check_fetch("t4_jmp", S_F0, 16'h0100);
        check("t4_jmp_pc", 32'(pc), 32'h0100);

        // END beats a simultaneous branch
        imem_ack = 1'b1; imem_data = 32'hFF000000;
        tick();
        imem_ack = 1'b0;
        jmp_valid = 1'b1; jmp_addr = 16'h0200;
        tick();
        jmp_valid = 1'b0;
        check("t5_halt_state", 32'(current_state), 32'(S_HALT));
        check("t5_halted",     32'(halted), 32'd1);
        check("t5_halt_req",   32'(imem_req), 32'd0);
        check("t5_halt_pc",    32'(pc), 32'h0100);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t5_halt_stay", 32'(current_state), 32'(S_HALT));
        start = 1'b1; start_pc = 16'h0000;
        tick();
        start = 1'b0;
        check_fetch("t5_restart", S_F0, 16'h0000);
        check("t5_restart_pc", 32'(pc), 32'h0000);
        check("t5_unhalted",   32'(halted), 32'd0);

        // Halt again, then LIMM32 at 0xFFFF wraps the second fetch to 0x0000
        imem_ack = 1'b1; imem_data = 32'hFF000000;
        tick();
        imem_ack = 1'b0;
        tick();
        check("t6_halt", 32'(current_state), 32'(S_HALT));
        start = 1'b1; start_pc = 16'hFFFF;
        tick();
        start = 1'b0;
        check_fetch("t6_f0", S_F0, 16'hFFFF);
        imem_ack = 1'b1; imem_data = 32'h02000000;
        tick();
        imem_ack = 1'b0;
        check_fetch("t6_f1_wrap", S_F1, 16'h0000);
        check("t6_f1_pc", 32'(pc), 32'hFFFF);

        // Asynchronous reset mid-FETCH1
        #3;
        reset_n = 1'b0;
        #1;
        check("t7_state",  32'(current_state), 32'(S_IDLE));
        check("t7_req",    32'(imem_req), 32'd0);
        check("t7_addr",   32'(imem_addr), 32'd0);
        check("t7_pc",     32'(pc), 32'd0);
        check("t7_instr0", instr0, 32'd0);
        check("t7_instr1", instr1, 32'd0);
        check("t7_halted", 32'(halted), 32'd0);
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        check("t7_post_state",  32'(current_state), 32'(S_IDLE));
        check("t7_post_req",    32'(imem_req), 32'd0);
        check("t7_post_instr1", instr1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
